// File: rtl/fft_sdf_sequencer_if.sv
// rtl/fft_sdf_sequencer_if.sv - handshake/status bundle between the SDF FFT sequencer and its user
// Carries out_idx only when FFT_OUT_INDEX_EN is defined.
interface fft_sdf_sequencer_if #(
  parameter int LOG2N = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [2*LOG2N-1:0] stage_state;
  logic               out_valid;
  logic               frame_start;
  logic               busy;
  logic               frame_err;
  logic               err_clr;
`ifdef FFT_OUT_INDEX_EN
  logic [LOG2N-1:0]   out_idx;
`endif

  modport master (
    output in_valid,
    output err_clr,
    input  in_ready,
    input  stage_state,
    input  out_valid,
    input  frame_start,
    input  busy,
    input  frame_err
`ifdef FFT_OUT_INDEX_EN
    , input out_idx
`endif
  );

  modport slave (
    input  in_valid,
    input  err_clr,
    output in_ready,
    output stage_state,
    output out_valid,
    output frame_start,
    output busy,
    output frame_err
`ifdef FFT_OUT_INDEX_EN
    , output out_idx
`endif
  );
endinterface

// File: rtl/fft_sdf_sequencer.sv
// rtl/fft_sdf_sequencer.sv - butterfly-state, valid-chain and flow-control sequencer for a radix-2 SDF FFT
// Optional FFT_OUT_INDEX_EN adds out_idx, the bit-reversed output counter (natural bin index).
module fft_sdf_sequencer #(
  parameter int N     = 32,
  parameter int LOG2N = 5
) (
  input  logic               clk,
  input  logic               rst,
  fft_sdf_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_FIRST   = 2'b01,
    ST_SECOND  = 2'b10,
    ST_WAITING = 2'b11
  } bf_state_e;

  typedef enum logic [1:0] {
    IN_IDLE,
    IN_STREAM,
    IN_PAD,
    IN_GAP
  } in_state_e;

  // Gap state covers N/2-1 cycles; the cycle that detects stream end is the first gap cycle.
  localparam logic [LOG2N-2:0] GAP_LOAD = (LOG2N-1)'(N/2 - 2);

  in_state_e        in_state_q, in_state_d;
  logic [LOG2N-1:0] in_cnt_q, in_cnt_d;
  logic [LOG2N-2:0] gap_cnt_q, gap_cnt_d;
  logic             rdy;
  logic             v0_in;
  logic             err_set;
  logic             frame_err_q, frame_err_d;

  logic [LOG2N:0]   v_q;
  logic [LOG2N-1:0] stage_out_v;
  logic [LOG2N-1:0] stage_v_in;
  logic [LOG2N-1:0] stage_act;
  logic [2*LOG2N-1:0] state_flat;

  logic             out_valid;
  logic [LOG2N-1:0] ocnt_q, ocnt_d;

  always_comb begin
    in_state_d = in_state_q;
    in_cnt_d   = in_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    rdy        = 1'b1;
    v0_in      = 1'b0;
    err_set    = 1'b0;
    case (in_state_q)
      IN_IDLE: begin
        if (bus.in_valid) begin
          v0_in      = 1'b1;
          in_cnt_d   = LOG2N'(1);
          in_state_d = IN_STREAM;
        end
      end
      IN_STREAM: begin
        if (bus.in_valid) begin
          v0_in    = 1'b1;
          in_cnt_d = in_cnt_q + LOG2N'(1);
        end else if (in_cnt_q == '0) begin
          rdy        = 1'b0;
          gap_cnt_d  = GAP_LOAD;
          in_state_d = IN_GAP;
        end else begin
          // Short frame: keep the pipeline sequencing with junk up to the frame boundary.
          err_set    = 1'b1;
          v0_in      = 1'b1;
          in_cnt_d   = in_cnt_q + LOG2N'(1);
          in_state_d = IN_PAD;
        end
      end
      IN_PAD: begin
        rdy     = 1'b0;
        err_set = bus.in_valid;
        if (in_cnt_q == '0) begin
          gap_cnt_d  = GAP_LOAD;
          in_state_d = IN_GAP;
        end else begin
          v0_in    = 1'b1;
          in_cnt_d = in_cnt_q + LOG2N'(1);
        end
      end
      IN_GAP: begin
        rdy     = 1'b0;
        err_set = bus.in_valid;
        if (gap_cnt_q == '0) begin
          in_state_d = IN_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - (LOG2N-1)'(1);
        end
      end
      default: in_state_d = IN_IDLE;
    endcase
  end

  always_comb begin
    frame_err_d = frame_err_q;
    if (err_set) begin
      frame_err_d = 1'b1;
    end else if (bus.err_clr) begin
      frame_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_state_q  <= IN_IDLE;
      in_cnt_q    <= '0;
      gap_cnt_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      in_state_q  <= in_state_d;
      in_cnt_q    <= in_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Stage k reacts to the valid that is being registered into v_q[k], so its state lines up with v_q[k].
  assign stage_v_in = {stage_out_v[LOG2N-2:0], v0_in};

  for (genvar k = 0; k < LOG2N; k++) begin : g_stage
    localparam int D  = N >> (k + 1);
    localparam int CW = (LOG2N - k - 1 > 0) ? (LOG2N - k - 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(D - 1);

    bf_state_e st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          primed_q, primed_d;
    logic          last;

    assign last = (cnt_q == CNT_LAST);

    always_comb begin
      st_d     = st_q;
      cnt_d    = last ? '0 : cnt_q + CW'(1);
      primed_d = primed_q;
      case (st_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (stage_v_in[k]) begin
            st_d = ST_WAITING;
          end
        end
        ST_WAITING: begin
          if (last) begin
            st_d     = ST_FIRST;
            primed_d = 1'b1;
          end
        end
        ST_FIRST: begin
          if (last) begin
            st_d = ST_SECOND;
          end
        end
        ST_SECOND: begin
          if (last) begin
            if (primed_q && v_q[k]) begin
              st_d = ST_FIRST;
            end else begin
              // Flush done; a new stream may already be arriving on this exact cycle.
              primed_d = 1'b0;
              st_d     = stage_v_in[k] ? ST_WAITING : ST_IDLE;
            end
          end
        end
        default: st_d = ST_IDLE;
      endcase
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        st_q     <= ST_IDLE;
        cnt_q    <= '0;
        primed_q <= 1'b0;
      end else begin
        st_q     <= st_d;
        cnt_q    <= cnt_d;
        primed_q <= primed_d;
      end
    end

    assign stage_out_v[k]     = (st_q == ST_FIRST) || (st_q == ST_SECOND);
    assign stage_act[k]       = (st_q != ST_IDLE) || primed_q;
    assign state_flat[2*k +: 2] = st_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q    <= '0;
      ocnt_q <= '0;
    end else begin
      v_q    <= {stage_out_v, v0_in};
      ocnt_q <= ocnt_d;
    end
  end

  assign out_valid = v_q[LOG2N];
  assign ocnt_d    = out_valid ? (ocnt_q + LOG2N'(1)) : '0;

  assign bus.in_ready    = rdy;
  assign bus.stage_state = state_flat;
  assign bus.out_valid   = out_valid;
  assign bus.frame_start = out_valid && (ocnt_q == '0);
  assign bus.busy        = (|stage_act) || (|v_q);
  assign bus.frame_err   = frame_err_q;

`ifdef FFT_OUT_INDEX_EN
  logic [LOG2N-1:0] ocnt_rev;

  always_comb begin
    ocnt_rev = '0;
    for (int i = 0; i < LOG2N; i++) begin
      ocnt_rev[i] = ocnt_q[LOG2N-1-i];
    end
  end

  assign bus.out_idx = out_valid ? ocnt_rev : '0;
`endif

endmodule

// File: tb/tb_fft_sdf_sequencer.sv
// tb/tb_fft_sdf_sequencer.sv - self-checking bench for fft_sdf_sequencer (table vectors, directed corners, random streams vs schedule model)
module tb_fft_sdf_sequencer;
  localparam int N     = 32;
  localparam int LOG2N = 5;

  localparam int S_ST0  = 0;
  localparam int S_ST   = 1;
  localparam int S_OV   = 2;
  localparam int S_FS   = 3;
  localparam int S_RDY  = 4;
  localparam int S_BUSY = 5;
  localparam int S_ERR  = 6;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] val;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   ss[$];
  int   sf[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  fft_sdf_sequencer_if #(.LOG2N(LOG2N)) bus ();

  fft_sdf_sequencer #(.N(N), .LOG2N(LOG2N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] get_sig(input int sig);
    case (sig)
      S_ST0:   return 32'(bus.stage_state[1:0]);
      S_ST:    return 32'(bus.stage_state);
      S_OV:    return 32'(bus.out_valid);
      S_FS:    return 32'(bus.frame_start);
      S_RDY:   return 32'(bus.in_ready);
      S_BUSY:  return 32'(bus.busy);
      default: return 32'(bus.frame_err);
    endcase
  endfunction

  function automatic string sig_name(input int sig);
    case (sig)
      S_ST0:   return "stage0_state";
      S_ST:    return "stage_state";
      S_OV:    return "out_valid";
      S_FS:    return "frame_start";
      S_RDY:   return "in_ready";
      S_BUSY:  return "busy";
      default: return "frame_err";
    endcase
  endfunction

  function automatic void add(input int cyc, input int sig, input logic [31:0] val);
    vec_t v;
    v.cyc = cyc;
    v.sig = sig;
    v.val = val;
    tbl.push_back(v);
  endfunction

  // Schedule model: stream i starts at ss[i] and is sf[i] whole frames long.
  function automatic int dly(input int k);
    return N >> (k + 1);
  endfunction

  function automatic int rstart(input int s, input int k);
    int r;
    r = s + 1;
    for (int j = 0; j < k; j++) r += dly(j) + 1;
    return r;
  endfunction

  function automatic logic [1:0] exp_state(input int k, input int t);
    for (int i = 0; i < ss.size(); i++) begin
      int r;
      int d;
      int l;
      r = rstart(ss[i], k);
      d = dly(k);
      l = sf[i] * N;
      if (t >= r && t < r + d) return 2'b11;
      if (t >= r + d && t < r + d + l) return (((t - r - d) / d) % 2 == 0) ? 2'b01 : 2'b10;
    end
    return 2'b00;
  endfunction

  function automatic logic exp_in_valid(input int t);
    for (int i = 0; i < ss.size(); i++)
      if (t >= ss[i] && t < ss[i] + sf[i] * N) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic exp_in_ready(input int t);
    for (int i = 0; i < ss.size(); i++) begin
      int e;
      e = ss[i] + sf[i] * N;
      if (t >= e && t < e + N / 2) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Returns output position within the stream, or -1 when out_valid should be low.
  function automatic int exp_out_pos(input int t);
    for (int i = 0; i < ss.size(); i++) begin
      int r;
      r = rstart(ss[i], LOG2N);
      if (t >= r && t < r + sf[i] * N) return t - r;
    end
    return -1;
  endfunction

  function automatic logic exp_busy(input int t);
    for (int i = 0; i < ss.size(); i++)
      if (t >= ss[i] + 1 && t < rstart(ss[i], LOG2N) + sf[i] * N) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [LOG2N-1:0] bitrev(input int v);
    logic [LOG2N-1:0] a;
    logic [LOG2N-1:0] b;
    a = LOG2N'(v);
    for (int i = 0; i < LOG2N; i++) b[i] = a[LOG2N-1-i];
    return b;
  endfunction

  task automatic do_reset();
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.err_clr  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_sched(input int ncyc, input string tag);
    for (int t = 0; t < ncyc; t++) begin
      logic [2*LOG2N-1:0] es;
      int p;
      bus.in_valid = exp_in_valid(t);
      bus.err_clr  = 1'b0;
      @(negedge clk);
      for (int k = 0; k < LOG2N; k++) es[2*k +: 2] = exp_state(k, t);
      p = exp_out_pos(t);
      check($sformatf("%s stage_state t=%0d", tag, t), 32'(bus.stage_state), 32'(es));
      check($sformatf("%s out_valid t=%0d", tag, t), 32'(bus.out_valid), 32'(p >= 0));
      check($sformatf("%s frame_start t=%0d", tag, t), 32'(bus.frame_start), 32'(p >= 0 && (p % N) == 0));
      check($sformatf("%s in_ready t=%0d", tag, t), 32'(bus.in_ready), 32'(exp_in_ready(t)));
      check($sformatf("%s busy t=%0d", tag, t), 32'(bus.busy), 32'(exp_busy(t)));
      check($sformatf("%s frame_err t=%0d", tag, t), 32'(bus.frame_err), 32'(0));
`ifdef FFT_OUT_INDEX_EN
      check($sformatf("%s out_idx t=%0d", tag, t), 32'(bus.out_idx), (p >= 0) ? 32'(bitrev(p % N)) : 32'(0));
`endif
      next_cycle();
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    int ovc;
    int t0;
    int f;

    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.err_clr  = 1'b0;

    // Single frame, in_valid cycles 0..31.
    add(0, S_ST, 0);   add(0, S_OV, 0);   add(0, S_RDY, 1);  add(0, S_BUSY, 0);
    add(0, S_ERR, 0);  add(0, S_FS, 0);
    add(1, S_ST0, 3);  add(16, S_ST0, 3); add(17, S_ST0, 1); add(32, S_ST0, 1);
    add(33, S_ST0, 2); add(48, S_ST0, 2); add(49, S_ST0, 0);
    add(36, S_OV, 0);  add(37, S_OV, 1);  add(68, S_OV, 1);  add(69, S_OV, 0);
    add(37, S_FS, 1);  add(38, S_FS, 0);  add(68, S_FS, 0);
    add(31, S_RDY, 1); add(32, S_RDY, 0); add(47, S_RDY, 0); add(48, S_RDY, 1);
    add(1, S_BUSY, 1); add(68, S_BUSY, 1); add(69, S_BUSY, 0); add(60, S_ERR, 0);

    do_reset();
    for (int t = 0; t < 80; t++) begin
      bus.in_valid = (t < 32);
      @(negedge clk);
      for (int i = 0; i < tbl.size(); i++)
        if (tbl[i].cyc == t)
          check($sformatf("vec %s t=%0d", sig_name(tbl[i].sig), t), get_sig(tbl[i].sig), tbl[i].val);
      next_cycle();
    end
    bus.in_valid = 1'b0;

    // Three back-to-back frames.
    do_reset();
    ss = '{0};
    sf = '{3};
    run_sched(150, "b2b");

    // Second stream after the minimum gap.
    do_reset();
    ss = '{0, 48};
    sf = '{1, 1};
    run_sched(140, "mingap");

    // Random streams with legal gaps.
    for (int it = 0; it < 3; it++) begin
      do_reset();
      ss.delete();
      sf.delete();
      t0 = int'($urandom_range(0, 5));
      for (int i = 0; i < 4; i++) begin
        f = int'($urandom_range(1, 3));
        ss.push_back(t0);
        sf.push_back(f);
        t0 += f * N + N / 2 + int'($urandom_range(0, 12));
      end
      run_sched(t0 + 50, $sformatf("rand%0d", it));
    end
    ss.delete();
    sf.delete();

    // Sample while not ready, err_clr, and error-beats-clear.
    do_reset();
    ovc = 0;
    for (int t = 0; t < 100; t++) begin
      bus.in_valid = (t < 32) || (t == 40) || (t == 45);
      bus.err_clr  = (t == 43) || (t == 45) || (t == 47);
      @(negedge clk);
      if (t == 39) check("err before", 32'(bus.frame_err), 32'(0));
      if (t == 40) check("ready at 40", 32'(bus.in_ready), 32'(0));
      if (t == 41) check("err set", 32'(bus.frame_err), 32'(1));
      if (t == 41) check("dropped sample st0", 32'(bus.stage_state[1:0]), 32'(2));
      if (t == 44) check("err cleared", 32'(bus.frame_err), 32'(0));
      if (t == 46) check("err beats clr", 32'(bus.frame_err), 32'(1));
      if (t == 48) check("err cleared 2", 32'(bus.frame_err), 32'(0));
      ovc += int'(bus.out_valid);
      next_cycle();
    end
    check("err run out_valid count", 32'(ovc), 32'(32));
    bus.in_valid = 1'b0;
    bus.err_clr  = 1'b0;

    // 20-sample stream is padded to a full frame and flagged.
    do_reset();
    ovc = 0;
    for (int t = 0; t < 90; t++) begin
      bus.in_valid = (t < 20);
      @(negedge clk);
      if (t == 20) check("short err pre", 32'(bus.frame_err), 32'(0));
      if (t == 21) check("short err", 32'(bus.frame_err), 32'(1));
      if (t == 25) check("short ready pad", 32'(bus.in_ready), 32'(0));
      if (t == 36) check("short ov 36", 32'(bus.out_valid), 32'(0));
      if (t == 37) check("short ov 37", 32'(bus.out_valid), 32'(1));
      if (t == 47) check("short ready 47", 32'(bus.in_ready), 32'(0));
      if (t == 48) check("short ready 48", 32'(bus.in_ready), 32'(1));
      ovc += int'(bus.out_valid);
      next_cycle();
    end
    check("short out_valid count", 32'(ovc), 32'(32));
    bus.in_valid = 1'b0;

    // Asynchronous reset at cycle 25 mid-stream, then a clean frame.
    do_reset();
    for (int t = 0; t < 25; t++) begin
      bus.in_valid = 1'b1;
      next_cycle();
    end
    @(negedge clk);
    check("pre-reset st0", 32'(bus.stage_state[1:0]), 32'(1));
    #1 rst = 1'b1;
    #1;
    check("async rst stage_state", 32'(bus.stage_state), 32'(0));
    check("async rst out_valid", 32'(bus.out_valid), 32'(0));
    check("async rst in_ready", 32'(bus.in_ready), 32'(1));
    check("async rst busy", 32'(bus.busy), 32'(0));
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int t = 0; t < 45; t++) begin
      bus.in_valid = (t < 32);
      @(negedge clk);
      if (t == 36) check("post-rst ov 36", 32'(bus.out_valid), 32'(0));
      if (t == 37) check("post-rst ov 37", 32'(bus.out_valid), 32'(1));
      if (t == 37) check("post-rst fs 37", 32'(bus.frame_start), 32'(1));
      next_cycle();
    end
    bus.in_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fft_sdf_sequencer.md
Name: fft_sdf_sequencer

Overview:
- Central controller for the 32-point radix-2 single-delay-feedback (SDF) FFT pipeline.
- Generates the 2-bit butterfly state (IDLE/FIRST/SECOND/WAITING) for every butterfly stage. Stage k has a shift-register delay of D_k = N>>(k+1).
- Tracks per-stage data validity through the one-register gap between stages, and flushes each stage at end of stream.
- Provides input flow control, output valid/frame markers and error reporting.
- Sits beside the butterfly/shift-register chain and drives all of its state inputs.

Parameters:
- N, 32, FFT length (power of two, 4..1024).
- LOG2N, 5, log2(N) = number of butterfly stages.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input sample present this cycle; a stream is a contiguous run of whole N-sample frames.
- in_ready  out  1  sequencer can accept in_valid this cycle.
- stage_state  out  2*LOG2N  stage k state at bits [2k+1:2k]; encoding is IDLE=00, FIRST=01, SECOND=10, WAITING=11.
- out_valid  out  1  registered output of the last stage is valid.
- frame_start  out  1  pulse on the first out_valid sample of each frame.
- busy  out  1  any stage not IDLE, or any valid in flight.
- frame_err  out  1  sticky protocol-error flag.
- err_clr  in  1  clears frame_err (synchronous).

Behaviour:
- Reset values: every stage state IDLE, all counters 0, all primed/valid flags 0, in_ready=1, out_valid=0, frame_start=0, busy=0, frame_err=0. Reset mid-stream aborts immediately; no flush is performed.
- Valid chain: v_0 = in_valid & in_ready, registered one cycle. v_{k+1} = v_k's stage output valid (state FIRST or SECOND), registered one cycle. out_valid = v_LOG2N. All state outputs are registered and apply in the cycle they are visible.
- Per stage k, with a counter cnt_k of width LOG2N-k-1 and a primed flag:
  - IDLE: on v_k=1 go to WAITING, cnt=0.
  - WAITING: lasts D_k cycles, then go to FIRST and set primed.
  - FIRST: lasts D_k cycles. At the end, go to SECOND.
  - SECOND with v_k=1: lasts D_k cycles, then go to FIRST (steady-state alternation).
  - SECOND with v_k=0 (flush): lasts D_k cycles, then go to IDLE and clear primed.
  - Because a stream is a multiple of N samples, v_k always falls at a FIRST→SECOND boundary, so stage output length equals input length.
- Latency: v_{k+1} rises D_k+1 cycles after v_k. Total delay from the first in_valid to out_valid is 1 + sum(D_k+1) = N + LOG2N cycles (37 for N=32).
- Flow control: in_ready drops for N/2 cycles after the last sample of a stream, covering the stage-0 flush. The gap then propagates, so every later stage finishes its flush before new data arrives.
- Boundary conditions:
  - in_valid=1 while in_ready=0: the sample is ignored and frame_err is set.
  - in_valid falling before a multiple of N samples: frame_err is set. Sequencing still proceeds to the next FIRST→SECOND boundary as if valid; the data there is junk.
  - err_clr asserted in the same cycle as a new error: the error wins.
- frame_start: a registered output counter (LOG2N bits) increments on each out_valid and clears when out_valid=0. frame_start = out_valid & (counter==0).

Optional Feature:
- FFT_OUT_INDEX_EN defined: adds output port out_idx [LOG2N-1:0]. It carries the bit-reversed value of the output counter, i.e. the natural frequency-bin index of the current out_valid sample, and is 0 when out_valid=0.
- FFT_OUT_INDEX_EN undefined: the port and its logic are absent. The output counter is still used for frame_start.

Test Plan:
- Reset then in_valid high cycles 0..31 (one frame), N=32:
  - stage_state[1:0]: WAITING cycles 1-16, FIRST 17-32, SECOND 33-48, IDLE from 49.
  - out_valid first at cycle 37 for exactly 32 cycles; frame_start only at 37.
- Three back-to-back frames (96 cycles):
  - stage 0 alternates FIRST/SECOND every 16 cycles with no WAITING after cycle 16.
  - out_valid high for 96 contiguous cycles; frame_start at cycles 37, 69 and 101.
- Second stream after the minimum gap:
  - in_ready=0 for cycles 32-47; in_valid at 48 is accepted.
  - Stage 0 goes WAITING at 49; no frame_err.
- Protocol errors:
  - in_valid at cycle 40 (in_ready=0) → frame_err=1, sample dropped.
  - err_clr → frame_err=0 next cycle.
  - A 20-sample stream → frame_err=1.
- Reset asserted at cycle 25 mid-stream → all stage_state=0, out_valid=0 and in_ready=1 immediately (asynchronous); a clean frame afterward produces out_valid 37 cycles after its start.
- With FFT_OUT_INDEX_EN: out_idx sequence 0,16,8,24,4,... over the 32 output cycles.
